// File: rtl/disp_scan.sv
// disp_scan: four-digit seven-segment scan controller.
// Divides clk into DIV-cycle digit slots and rotates a one-hot select.
// Each slot opens with DEAD cycles of all-zero select so that adjacent
// digits never ghost. All outputs are registered.
module disp_scan #(
    parameter int DIV  = 16384,  // clock cycles per digit slot, 2..65535
    parameter int DEAD = 64,     // blanking cycles at slot start, < DIV
    parameter int CW   = 16      // prescaler width, 2**CW >= DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] blank,
    output logic [3:0] sel,
    output logic [3:0] an,
    output logic [1:0] digit_idx,
    output logic       frame
);

    typedef enum logic {
        PH_DEAD = 1'b0,
        PH_ON   = 1'b1
    } phase_t;

    localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);

    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    idx, idx_nxt;
    phase_t        phase, phase_nxt;
    logic          wrap;
    logic          in_dead;
    logic [3:0]    sel_nxt;
    logic          frame_nxt;

    // Prescaler and slot index advance; both hold while the scan is paused.
    // NOTE: every signal written here gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_nxt = cnt;
        idx_nxt = idx;
        wrap    = 1'b0;
        if (en) begin
            if (cnt == DIV_M1) begin
                cnt_nxt = '0;
                idx_nxt = idx + 2'd1;
                wrap    = (idx == 2'd3);
            end else begin
                cnt_nxt = cnt + CW'(1);
            end
        end
    end

    // Dead-time window test on the updated count; with no dead-time the
    // window is empty, so the comparison is left out altogether.
    if (DEAD == 0) begin : g_no_dead
        assign in_dead = 1'b0;
    end else begin : g_dead
        assign in_dead = (cnt_nxt < CW'(DEAD));
    end

    // Phase next-state and the select/frame values to be registered.
    always_comb begin
        phase_nxt = phase;
        sel_nxt   = 4'b0000;
        frame_nxt = 1'b0;
        if (en) begin
            phase_nxt = in_dead ? PH_DEAD : PH_ON;
            frame_nxt = wrap;
            if (phase_nxt == PH_ON && !blank[idx_nxt]) begin
                sel_nxt = 4'b0001 << idx_nxt;
            end
        end
    end

    // State and output registers; reset overrides the enable.
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            idx       <= 2'd0;
            phase     <= PH_DEAD;
            sel       <= 4'b0000;
            an        <= 4'b1111;
            digit_idx <= 2'd0;
            frame     <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            phase     <= phase_nxt;
            sel       <= sel_nxt;
            an        <= ~sel_nxt;
            digit_idx <= idx_nxt;
            frame     <= frame_nxt;
        end
    end

endmodule
